wb_arbiter: RTL and testbench

- Sits between two 32-bit Wishbone masters and up to four Wishbone slave peripherals in the MCU.
- Master 0 is the spif Wishbone port; master 1 is a future DMA/debug master.
- Arbitrates round-robin, decodes the slave from the top address bits, registers the request, and returns ack/data to the winner.
- A watchdog terminates any access a slave never acknowledges, flagging an error instead of hanging the CPU.

---
 rtl/mcu_pkg.sv | 23 ++
 rtl/wb_arbiter_if.sv | 56 +++++
 rtl/wb_timeout.sv | 28 ++
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared MCU bus constants, arbiter state encoding and helpers
package mcu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int NSLAVES   = 4;
    localparam int SLV_WBREG = 0;
    localparam int SLV_GPIO  = 1;
    localparam int SLV_TIMER = 2;
    localparam int SLV_SPARE = 3;

    // Read data returned to a master whose access was terminated by the watchdog
    localparam logic [31:0] TO_DATA = 32'h0;

    function automatic logic [NSLAVES-1:0] slave_onehot(input logic [1:0] sel);
        return NSLAVES'(1) << sel;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - two-master / four-slave Wishbone bundle around the arbiter
interface wb_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 32
);
    import mcu_pkg::*;

    logic [AW-1:0]         m0_adr;
    logic [DW-1:0]         m0_dat_o;
    logic                  m0_we;
    logic                  m0_stb;
    logic [DW-1:0]         m0_dat_i;
    logic                  m0_ack;
    logic                  m0_err;

    logic [AW-1:0]         m1_adr;
    logic [DW-1:0]         m1_dat_o;
    logic                  m1_we;
    logic                  m1_stb;
    logic [DW-1:0]         m1_dat_i;
    logic                  m1_ack;
    logic                  m1_err;

    logic [AW-1:0]         s_adr;
    logic [DW-1:0]         s_dat_o;
    logic                  s_we;
    logic [NSLAVES-1:0]    s_stb;
    logic [NSLAVES-1:0]    s_ack;
    logic [NSLAVES*DW-1:0] s_dat_i;

    logic                  busy;
    logic                  owner;

    // Arbiter side: target of both masters, initiator towards the slaves
    modport slave (
        input  m0_adr, m0_dat_o, m0_we, m0_stb,
        output m0_dat_i, m0_ack, m0_err,
        input  m1_adr, m1_dat_o, m1_we, m1_stb,
        output m1_dat_i, m1_ack, m1_err,
        output s_adr, s_dat_o, s_we, s_stb,
        input  s_ack, s_dat_i,
        output busy, owner
    );

    // Environment side: the masters and slave peripherals around the arbiter
    modport master (
        output m0_adr, m0_dat_o, m0_we, m0_stb,
        input  m0_dat_i, m0_ack, m0_err,
        output m1_adr, m1_dat_o, m1_we, m1_stb,
        input  m1_dat_i, m1_ack, m1_err,
        input  s_adr, s_dat_o, s_we, s_stb,
        output s_ack, s_dat_i,
        input  busy, owner
    );

endinterface

// File: rtl/wb_timeout.sv
// rtl/wb_timeout.sv - loadable down-counter that flags expiry on reaching zero
module wb_timeout #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    // Parks at zero so expired stays asserted until the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin two-master Wishbone arbiter with slave decode and ack watchdog
module wb_arbiter
    import mcu_pkg::*;
#(
    parameter int AW      = 15,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    arb_state_t    state;
    logic          win;
    logic [AW-1:0] win_adr;
    logic [DW-1:0] win_dat;
    logic          win_we;
    logic [1:0]    sel;
    logic          grant;
    logic          to_expired;

    // A lone requester wins; on a tie the master that did not go last wins
    always_comb begin
        if (bus.m0_stb && bus.m1_stb) begin
            win = ~bus.owner;
        end else begin
            win = bus.m1_stb;
        end
        win_adr = win ? bus.m1_adr   : bus.m0_adr;
        win_dat = win ? bus.m1_dat_o : bus.m0_dat_o;
        win_we  = win ? bus.m1_we    : bus.m0_we;
    end

    assign grant    = (state == ST_IDLE) && (bus.m0_stb || bus.m1_stb);
    assign sel      = bus.s_adr[AW-1:AW-2];
    assign bus.busy = (state != ST_IDLE);

    // Loaded with TIMEOUT-1 at grant so expiry lines up with the TIMEOUT-th BUSY cycle
    wb_timeout #(.W(TOW)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant),
        .load_val (TOW'(TIMEOUT - 1)),
        .en       (state == ST_BUSY),
        .expired  (to_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bus.owner    <= 1'b1;
            bus.s_adr    <= '0;
            bus.s_dat_o  <= '0;
            bus.s_we     <= 1'b0;
            bus.s_stb    <= '0;
            bus.m0_dat_i <= '0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m1_dat_i <= '0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m0_err <= 1'b0;
            bus.m1_ack <= 1'b0;
            bus.m1_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        bus.owner   <= win;
                        bus.s_adr   <= win_adr;
                        bus.s_dat_o <= win_dat;
                        bus.s_we    <= win_we;
                        bus.s_stb   <= slave_onehot(win_adr[AW-1:AW-2]);
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A real ack beats a watchdog expiry in the same cycle
                    if (bus.s_ack[sel] || to_expired) begin
                        if (bus.owner) begin
                            bus.m1_ack   <= 1'b1;
                            bus.m1_err   <= ~bus.s_ack[sel];
                            bus.m1_dat_i <= bus.s_ack[sel] ? bus.s_dat_i[sel*DW +: DW] : DW'(TO_DATA);
                        end else begin
                            bus.m0_ack   <= 1'b1;
                            bus.m0_err   <= ~bus.s_ack[sel];
                            bus.m0_dat_i <= bus.s_ack[sel] ? bus.s_dat_i[sel*DW +: DW] : DW'(TO_DATA);
                        end
                        bus.s_stb <= '0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed scoreboard bench for the Wishbone arbiter
module tb_wb_arbiter;

    localparam int AW      = 15;
    localparam int DW      = 32;
    localparam int TIMEOUT = 255;

    typedef struct {
        bit          m;
        bit          err;
        logic [31:0] dat;
    } exp_t;

    logic clk;
    logic rst_n;

    wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TOW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned   slv_delay [4];
    logic [31:0]   slv_data  [4];
    bit            slv_never [4];
    logic [3:0]    stray;
    int unsigned   wait_cnt;
    logic [3:0]    ack_v;
    logic [127:0]  dat_v;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rem0  = 0;
    int   rem1  = 0;
    int   n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            wait_cnt <= 0;
        else if (|bus.s_stb)   wait_cnt <= wait_cnt + 1;
        else                   wait_cnt <= 0;
    end

    always_comb begin
        ack_v = '0;
        dat_v = '0;
        for (int k = 0; k < 4; k++) begin
            ack_v[k]         = bus.s_stb[k] && !slv_never[k] && (wait_cnt == slv_delay[k]);
            dat_v[k*32 +: 32] = slv_data[k];
        end
    end

    assign bus.s_ack   = ack_v | stray;
    assign bus.s_dat_i = dat_v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit m, input bit err, input logic [31:0] dat);
        exp_t e;
        e.m = m; e.err = err; e.dat = dat;
        sb.push_back(e);
    endtask

    // One clock: sample at the falling edge, score any ack, let the master drop stb
    task automatic cyc();
        exp_t e;
        bit   am;
        @(negedge clk);
        if (bus.m0_ack || bus.m1_ack) begin
            check("single_ack", {63'd0, bus.m0_ack & bus.m1_ack}, 64'd0);
            check("unexpected_ack", {63'd0, sb.size() == 0}, 64'd0);
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                am = bus.m1_ack;
                check("ack_master", {63'd0, am}, {63'd0, e.m});
                check("ack_err", {63'd0, am ? bus.m1_err : bus.m0_err}, {63'd0, e.err});
                check("ack_dat", {32'd0, am ? bus.m1_dat_i : bus.m0_dat_i}, {32'd0, e.dat});
                if (!am) begin
                    if (rem0 > 0) rem0--;
                    if (rem0 == 0) bus.m0_stb = 1'b0;
                end else begin
                    if (rem1 > 0) rem1--;
                    if (rem1 == 0) bus.m1_stb = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int budget, output int cycles);
        cycles = 0;
        while (sb.size() != 0 && cycles < budget) begin
            cyc();
            cycles++;
        end
        check("sb_drained", sb.size(), 64'd0);
    endtask

    task automatic req(input bit m, input logic [AW-1:0] adr, input logic [31:0] dat, input bit we, input int rep);
        if (!m) begin
            bus.m0_adr = adr; bus.m0_dat_o = dat; bus.m0_we = we; bus.m0_stb = 1'b1; rem0 = rep;
        end else begin
            bus.m1_adr = adr; bus.m1_dat_o = dat; bus.m1_we = we; bus.m1_stb = 1'b1; rem1 = rep;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            slv_delay[k] = 0;
            slv_data[k]  = 32'hA000_0000 | k;
            slv_never[k] = 1'b0;
        end
        stray = '0;
        bus.m0_adr = '0; bus.m0_dat_o = '0; bus.m0_we = 1'b0; bus.m0_stb = 1'b0;
        bus.m1_adr = '0; bus.m1_dat_o = '0; bus.m1_we = 1'b0; bus.m1_stb = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_stb", bus.s_stb, 64'd0);
        check("rst_busy", bus.busy, 64'd0);
        check("rst_owner", bus.owner, 64'd1);
        check("rst_acks", {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err}, 64'd0);
        check("rst_s_adr", bus.s_adr, 64'd0);
        rst_n = 1'b1;
        cyc();

        // Single read, slave 1 acks in its 4th BUSY cycle
        slv_delay[1] = 3;
        slv_data[1]  = 32'h1234_5678;
        req(0, 15'h2004, 32'h0, 1'b0, 1);
        push(0, 0, 32'h1234_5678);
        cyc();
        check("rd_s_stb", bus.s_stb, 64'b0010);
        check("rd_s_adr", bus.s_adr, 64'h2004);
        check("rd_s_we", bus.s_we, 64'd0);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (!bus.busy) break;
            n++;
        end
        check("rd_busy_cycles", n, 64'd5);
        check("rd_sb_drained", sb.size(), 64'd0);
        check("rd_dat_hold", bus.m0_dat_i, 64'h1234_5678);

        // Write from m1, slave 0 acks combinationally
        slv_delay[0] = 0;
        slv_data[0]  = 32'h0BAD_0000;
        req(1, 15'h0010, 32'hCAFE_F00D, 1'b1, 1);
        push(1, 0, 32'h0BAD_0000);
        cyc();
        check("wr_s_dat_o", bus.s_dat_o, 64'hCAFE_F00D);
        check("wr_s_we", bus.s_we, 64'd1);
        check("wr_s_stb", bus.s_stb, 64'b0001);
        cyc();
        check("wr_m1_ack_2cyc", bus.m1_ack, 64'd1);
        check("wr_m0_ack_quiet", bus.m0_ack, 64'd0);
        cyc();

        // Contention: both strobe together three times each, round-robin from owner=1
        slv_delay[0] = 1;
        slv_delay[2] = 0;
        slv_data[2]  = 32'h2222_0002;
        for (int k = 0; k < 3; k++) begin
            push(0, 0, 32'h0BAD_0000);
            push(1, 0, 32'h2222_0002);
        end
        req(0, 15'h0000, 32'h0, 1'b0, 3);
        req(1, 15'h4008, 32'h0, 1'b0, 3);
        run(100, n);
        check("cont_owner_last", bus.owner, 64'd1);
        cyc();
        cyc();
        check("cont_idle", bus.busy, 64'd0);

        // Watchdog: slave 3 never acks
        slv_never[3] = 1'b1;
        req(0, 15'h6000, 32'h0, 1'b0, 1);
        push(0, 1, 32'h0);
        run(400, n);
        check("to_latency", n, 64'(TIMEOUT + 1));
        check("to_s_stb", bus.s_stb, 64'd0);
        cyc();
        cyc();
        slv_delay[1] = 0;
        slv_data[1]  = 32'h5555_AAAA;
        req(0, 15'h2000, 32'h0, 1'b0, 1);
        push(0, 0, 32'h5555_AAAA);
        run(20, n);
        check("after_to_latency", n, 64'd2);
        cyc();
        cyc();

        // Ack in the last BUSY cycle before expiry, plus a stray ack from slave 2
        slv_delay[1] = TIMEOUT - 1;
        slv_data[1]  = 32'h0FED_CBA9;
        stray        = 4'b0100;
        req(0, 15'h2010, 32'h0, 1'b0, 1);
        push(0, 0, 32'h0FED_CBA9);
        run(400, n);
        check("race_latency", n, 64'(TIMEOUT + 1));
        stray = '0;
        cyc();
        cyc();

        // Reset in the middle of an m0 access
        req(0, 15'h6004, 32'h0, 1'b0, 1);
        repeat (4) cyc();
        check("mid_busy", bus.busy, 64'd1);
        check("mid_owner", bus.owner, 64'd0);
        rst_n = 1'b0;
        bus.m0_stb = 1'b0;
        #1;
        check("mid_rst_s_stb", bus.s_stb, 64'd0);
        check("mid_rst_busy", bus.busy, 64'd0);
        check("mid_rst_owner", bus.owner, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        slv_never[3] = 1'b0;
        slv_delay[0] = 0;
        cyc();
        push(0, 0, 32'h0BAD_0000);
        push(1, 0, 32'h0BAD_0000);
        req(0, 15'h0020, 32'h0, 1'b0, 1);
        req(1, 15'h0024, 32'h0, 1'b0, 1);
        run(40, n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
